// File: rtl/wb_store_buffer_pkg.sv
// Shared types for the writeback store buffer: size encodings, drain FSM
// states and the store-entry record.
package wb_store_buffer_pkg;

   localparam int SB_AW = 32;
   localparam int SB_DW = 32;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_WORD  = 2'b01;
   localparam logic [1:0] SZ_DWORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2
   } sb_state_e;

   typedef struct packed {
      logic [SB_AW-1:0] addr;
      logic [SB_DW-1:0] data;
      logic [1:0]       size;
   } sb_entry_t;

   // The reserved size code is stored as a dword so the dcache never sees it.
   function automatic logic [1:0] sb_norm_size(input logic [1:0] s);
      return (s == 2'b11) ? SZ_DWORD : s;
   endfunction

endpackage

// File: rtl/wb_store_buffer_addr_match.sv
// sb_addr_match: per-entry dword-granular address comparators plus the index
// of the youngest matching entry (age measured from the read pointer).
module sb_addr_match #(
   parameter int DEPTH = 4,
   parameter int AW    = 32,
   parameter int IW    = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0][AW-1:0] ent_addr_i,
   input  logic [DEPTH-1:0]         ent_vld_i,
   input  logic [IW-1:0]            rd_ptr_i,
   input  logic [AW-1:0]            ld_addr_i,
   output logic [DEPTH-1:0]         match_o,
   output logic [IW-1:0]            young_idx_o
);

   logic [IW-1:0] idx;

   for (genvar g = 0; g < DEPTH; g++) begin : g_cmp
      assign match_o[g] = ent_vld_i[g] && (ent_addr_i[g][AW-1:2] == ld_addr_i[AW-1:2]);
   end

   // Walk from oldest to newest; the last hit seen is the youngest.
   always_comb begin
      idx         = '0;
      young_idx_o = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_ptr_i + IW'(k);
         if (match_o[idx]) young_idx_o = idx;
      end
   end

endmodule

// File: rtl/wb_store_buffer.sv
// Writeback store buffer: DEPTH-entry FIFO of retired stores drained to the
// dcache with a valid/ack handshake, load-conflict check and halt drain.
// Optional store-to-load forwarding: define WB_STORE_FWD_EN.
module wb_store_buffer
   import wb_store_buffer_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = SB_AW,
   parameter int DW    = SB_DW
) (
   input  logic          CLK,
   input  logic          CLR,
   input  logic          v_ex_dcache_write,
   input  logic [AW-1:0] wb_st_addr,
   input  logic [DW-1:0] wb_st_data,
   input  logic [1:0]    wb_st_size,
   input  logic          wb_halt_all,
   input  logic [AW-1:0] ld_chk_addr,
   input  logic          ld_chk_v,
   input  logic          dc_wr_ack,
   output logic          sb_req_valid,
   output logic [AW-1:0] sb_req_addr,
   output logic [DW-1:0] sb_req_data,
   output logic [1:0]    sb_req_size,
   output logic          sb_stall_wb,
   output logic          sb_ld_conflict,
   output logic          sb_drained,
   output logic          sb_overflow_err
`ifdef WB_STORE_FWD_EN
   ,
   output logic          sb_fwd_hit,
   output logic [DW-1:0] sb_fwd_data
`endif
);

   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;

   logic [DEPTH-1:0][AW-1:0] addr_q;
   logic [DEPTH-1:0][DW-1:0] data_q;
   logic [DEPTH-1:0][1:0]    size_q;
   logic [DEPTH-1:0]         vld_q;
   logic [IW-1:0]            wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]            cnt_q;
   logic                     ovf_q, armed_q, drained_q;
   sb_state_e                state_q;

   logic full, push, pop;
   logic [DEPTH-1:0] match;

   assign full  = (cnt_q == CW'(DEPTH));
   assign push  = v_ex_dcache_write && !full;
   assign pop   = (cnt_q != '0) && dc_wr_ack;

   assign sb_req_valid    = (cnt_q != '0);
   assign sb_req_addr     = sb_req_valid ? addr_q[rd_ptr_q] : '0;
   assign sb_req_data     = sb_req_valid ? data_q[rd_ptr_q] : '0;
   assign sb_req_size     = sb_req_valid ? size_q[rd_ptr_q] : '0;
   assign sb_stall_wb     = full;
   assign sb_drained      = drained_q;
   assign sb_overflow_err = ovf_q;

`ifdef WB_STORE_FWD_EN
   logic [IW-1:0] young;
   logic          exact;
`else
   logic [IW-1:0] young_unused;
`endif

   sb_addr_match #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_match (
      .ent_addr_i  (addr_q),
      .ent_vld_i   (vld_q),
      .rd_ptr_i    (rd_ptr_q),
      .ld_addr_i   (ld_chk_addr),
      .match_o     (match),
`ifdef WB_STORE_FWD_EN
      .young_idx_o (young)
`else
      .young_idx_o (young_unused)
`endif
   );

`ifdef WB_STORE_FWD_EN
   // Forward only when the youngest overlapping store covers the load exactly.
   assign exact          = (addr_q[young] == ld_chk_addr) && (size_q[young] == SZ_DWORD);
   assign sb_fwd_hit     = ld_chk_v && (|match) && exact;
   assign sb_fwd_data    = sb_fwd_hit ? data_q[young] : '0;
   assign sb_ld_conflict = ld_chk_v && (|match) && !exact;
`else
   assign sb_ld_conflict = ld_chk_v && (|match);
`endif

   // Entry storage and valid bits; push writes at the tail, pop clears the head.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         addr_q <= '0;
         data_q <= '0;
         size_q <= '0;
         vld_q  <= '0;
      end else begin
         if (pop) vld_q[rd_ptr_q] <= 1'b0;
         if (push) begin
            addr_q[wr_ptr_q] <= wb_st_addr;
            data_q[wr_ptr_q] <= wb_st_data;
            size_q[wr_ptr_q] <= sb_norm_size(wb_st_size);
            vld_q[wr_ptr_q]  <= 1'b1;
         end
      end
   end

   // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Sticky error, halt arming and registered drained flag.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         ovf_q     <= 1'b0;
         armed_q   <= 1'b0;
         drained_q <= 1'b0;
      end else begin
         ovf_q     <= ovf_q | (v_ex_dcache_write && full) | (push && wb_st_size == 2'b11);
         armed_q   <= armed_q | wb_halt_all;
         drained_q <= armed_q && (cnt_q == '0);
      end
   end

   // Drain controller: DRAIN once halt is armed, still accepting pushes.
   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         state_q <= ST_IDLE;
      end else if (armed_q) begin
         state_q <= ST_DRAIN;
      end else begin
         case (state_q)
            ST_IDLE: if (push) state_q <= ST_BUSY;
            ST_BUSY: if (pop && !push && cnt_q == CW'(1)) state_q <= ST_IDLE;
            default: state_q <= state_q;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_store_buffer.sv
// Scoreboard bench for wb_store_buffer: a queue-based model predicts the
// buffer contents; a negedge monitor checks the DUT against it every cycle.
module tb_wb_store_buffer;
   import wb_store_buffer_pkg::*;

   localparam int DEPTH = 4;
   localparam int AW    = 32;
   localparam int DW    = 32;

   logic          CLK = 1'b0;
   logic          CLR = 1'b0;
   logic          v_ex_dcache_write = 1'b0;
   logic [AW-1:0] wb_st_addr = '0;
   logic [DW-1:0] wb_st_data = '0;
   logic [1:0]    wb_st_size = '0;
   logic          wb_halt_all = 1'b0;
   logic [AW-1:0] ld_chk_addr = '0;
   logic          ld_chk_v = 1'b0;
   logic          dc_wr_ack = 1'b0;
   logic          sb_req_valid, sb_stall_wb, sb_ld_conflict, sb_drained, sb_overflow_err;
   logic [AW-1:0] sb_req_addr;
   logic [DW-1:0] sb_req_data;
   logic [1:0]    sb_req_size;
`ifdef WB_STORE_FWD_EN
   logic          sb_fwd_hit;
   logic [DW-1:0] sb_fwd_data;
`endif

   wb_store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .CLK(CLK), .CLR(CLR),
      .v_ex_dcache_write(v_ex_dcache_write), .wb_st_addr(wb_st_addr),
      .wb_st_data(wb_st_data), .wb_st_size(wb_st_size), .wb_halt_all(wb_halt_all),
      .ld_chk_addr(ld_chk_addr), .ld_chk_v(ld_chk_v), .dc_wr_ack(dc_wr_ack),
      .sb_req_valid(sb_req_valid), .sb_req_addr(sb_req_addr), .sb_req_data(sb_req_data),
      .sb_req_size(sb_req_size), .sb_stall_wb(sb_stall_wb), .sb_ld_conflict(sb_ld_conflict),
      .sb_drained(sb_drained), .sb_overflow_err(sb_overflow_err)
`ifdef WB_STORE_FWD_EN
      , .sb_fwd_hit(sb_fwd_hit), .sb_fwd_data(sb_fwd_data)
`endif
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Model state. exp_q holds every accepted store in order; the tail entry is
   // not yet inside the DUT while pend_push is set (it lands at the next edge).
   sb_entry_t exp_q[$];
   int  pend_push = 0;
   int  last_cnt  = 0;
   bit  ovf_m = 0, ovf_pend = 0, arm_m = 0, halt_last = 0, drained_m = 0;
   bit  mon_en = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus, issued just after a rising edge.
   task automatic cyc(input bit v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [1:0] s, input bit ack, input bit halt,
                      input bit ldv, input logic [AW-1:0] la);
      sb_entry_t e;
      drained_m = arm_m && (last_cnt == 0);
      ovf_m     = ovf_m | ovf_pend;
      if (halt_last) arm_m = 1'b1;
      last_cnt  = exp_q.size();
      ovf_pend  = v && ((exp_q.size() == DEPTH) || (s == 2'b11));
      pend_push = 0;
      if (v && exp_q.size() < DEPTH) begin
         e.addr = a;
         e.data = d;
         e.size = (s == 2'b11) ? SZ_DWORD : s;
         exp_q.push_back(e);
         pend_push = 1;
      end
      v_ex_dcache_write = v; wb_st_addr = a; wb_st_data = d; wb_st_size = s;
      dc_wr_ack = ack; wb_halt_all = halt; ld_chk_v = ldv; ld_chk_addr = la;
      halt_last = halt;
      @(posedge CLK); #1;
   endtask

   task automatic idle(input bit ack, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 2'b00, ack, 1'b0, 1'b0, '0);
   endtask

   task automatic model_reset();
      exp_q.delete();
      pend_push = 0; last_cnt = 0;
      ovf_m = 0; ovf_pend = 0; arm_m = 0; halt_last = 0; drained_m = 0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_valid"},    64'(sb_req_valid), 64'd0);
      chk({tag, "_addr"},     64'(sb_req_addr), 64'd0);
      chk({tag, "_data"},     64'(sb_req_data), 64'd0);
      chk({tag, "_size"},     64'(sb_req_size), 64'd0);
      chk({tag, "_stall"},    64'(sb_stall_wb), 64'd0);
      chk({tag, "_conflict"}, 64'(sb_ld_conflict), 64'd0);
      chk({tag, "_drained"},  64'(sb_drained), 64'd0);
      chk({tag, "_ovf"},      64'(sb_overflow_err), 64'd0);
   endtask

   // Monitor: compare flags and head fields every cycle; retire on model pop.
   int mon_n;
   bit mon_conf;
   int mon_young;
   always @(negedge CLK) begin
      if (mon_en) begin
         mon_n = exp_q.size() - pend_push;
         chk("req_valid", 64'(sb_req_valid), 64'(mon_n != 0));
         chk("stall_wb",  64'(sb_stall_wb),  64'(mon_n == DEPTH));
         chk("overflow",  64'(sb_overflow_err), 64'(ovf_m));
         chk("drained",   64'(sb_drained),   64'(drained_m));
         mon_conf  = 1'b0;
         mon_young = -1;
         for (int i = 0; i < mon_n; i++)
            if (ld_chk_v && exp_q[i].addr[AW-1:2] == ld_chk_addr[AW-1:2]) begin
               mon_conf  = 1'b1;
               mon_young = i;
            end
`ifdef WB_STORE_FWD_EN
         if (mon_conf && exp_q[mon_young].addr == ld_chk_addr && exp_q[mon_young].size == SZ_DWORD) begin
            chk("fwd_hit",  64'(sb_fwd_hit), 64'd1);
            chk("fwd_data", 64'(sb_fwd_data), 64'(exp_q[mon_young].data));
            mon_conf = 1'b0;
         end else begin
            chk("fwd_hit",  64'(sb_fwd_hit), 64'd0);
         end
`endif
         chk("ld_conflict", 64'(sb_ld_conflict), 64'(mon_conf));
         if (mon_n > 0) begin
            chk("head_addr", 64'(sb_req_addr), 64'(exp_q[0].addr));
            chk("head_data", 64'(sb_req_data), 64'(exp_q[0].data));
            chk("head_size", 64'(sb_req_size), 64'(exp_q[0].size));
            if (dc_wr_ack) void'(exp_q.pop_front());
         end
      end
   end

   logic [AW-1:0] ra, la;

   initial begin
      // Reset state.
      #12;
      chk_all_zero("rst");
      @(negedge CLK); CLR = 1'b1;
      @(posedge CLK); #1;
      mon_en = 1'b1;

      // Single store held three cycles, then acked.
      cyc(1'b1, 32'h1000, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, 1'b0, '0);
      idle(1'b0, 3);
      idle(1'b1, 1);
      idle(1'b0, 2);

      // Fill to full, then a push with ack while full is dropped.
      for (int i = 0; i < 4; i++)
         cyc(1'b1, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 2'b01, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, 32'h1F0, 32'hBAD, 2'b10, 1'b1, 1'b0, 1'b0, '0);
      idle(1'b1, 5);

      // Push and ack every cycle: pointers wrap, occupancy stays at most 1.
      for (int i = 0; i < 10; i++)
         cyc(1'b1, 32'(i * 4), 32'h5000 + 32'(i), 2'b10, 1'b1, 1'b0, 1'b0, '0);
      idle(1'b1, 2);

      // Load conflict checks against a pending store at 0x2004.
      cyc(1'b1, 32'h2004, 32'hCAFE0001, 2'b10, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h2006);
      cyc(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h2008);
      cyc(1'b0, '0, '0, 2'b00, 1'b0, 1'b0, 1'b1, 32'h2004);
      cyc(1'b0, '0, '0, 2'b00, 1'b1, 1'b0, 1'b1, 32'h2005);
      idle(1'b0, 1);

      // Reset mid-handshake with three entries pending.
      for (int i = 0; i < 3; i++)
         cyc(1'b1, 32'h700 + 32'(i * 8), 32'h77 + 32'(i), 2'b00, 1'b0, 1'b0, 1'b0, '0);
      dc_wr_ack = 1'b1; ld_chk_v = 1'b1; ld_chk_addr = 32'h700;
      v_ex_dcache_write = 1'b0;
      mon_en = 1'b0;
      #2 CLR = 1'b0;
      #1 chk_all_zero("midrst");
      model_reset();
      @(negedge CLK); CLR = 1'b1;
      @(posedge CLK); #1;
      mon_en = 1'b1;
      idle(1'b1, 3);

      // Reserved size is accepted as a dword and flags the error.
      cyc(1'b1, 32'h880, 32'h12345678, 2'b11, 1'b0, 1'b0, 1'b0, '0);
      idle(1'b0, 1);
      idle(1'b1, 2);

      // Randomized traffic over a small address pool to provoke conflicts.
      for (int i = 0; i < 400; i++) begin
         ra = 32'h3000 + 32'($urandom_range(0, 15) * 2);
         la = 32'h3000 + 32'($urandom_range(0, 15) * 2);
         cyc(1'($urandom_range(0, 1)), ra, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 2) == 0), 1'b0, 1'($urandom_range(0, 1)), la);
      end
      idle(1'b1, 6);

      // Halt with two pending stores, then drain.
      cyc(1'b1, 32'h9000, 32'h11, 2'b10, 1'b0, 1'b0, 1'b0, '0);
      cyc(1'b1, 32'h9008, 32'h22, 2'b10, 1'b0, 1'b1, 1'b0, '0);
      idle(1'b0, 2);
      idle(1'b1, 2);
      idle(1'b0, 3);
      chk("fsm_drain", 64'(dut.state_q), 64'(ST_DRAIN));
      // Pushes are still accepted while draining.
      cyc(1'b1, 32'h9010, 32'h33, 2'b10, 1'b0, 1'b0, 1'b0, '0);
      idle(1'b1, 1);
      idle(1'b0, 3);

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
